game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 124 ++++++++++++
 tb/tb_game_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: match state machine with debounced start/pause buttons and round clear
module game_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int POINT_MS    = 1000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_ms,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [3:0] p1_score,
  input  logic [3:0] p2_score,
  output logic [1:0] game_state,
  output logic [1:0] winner,
  output logic       round_rst_n
);
  localparam int TW = $clog2(POINT_MS + 1);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, POINT = 2'b10, OVER = 2'b11} state_t;

  logic [1:0] btn, press;
  assign btn = {btn_pause, btn_start};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic s1_q, s2_q, deb_q, done;
    logic [DW-1:0] cnt_q;
    assign done = cnt_q == DW'(DEBOUNCE_MS - 1);
    assign press[b] = tick_ms & done & s2_q & ~deb_q;
    // synchronize, then accept a new level only after it holds for DEBOUNCE_MS ticks
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q <= btn[b];
        s2_q <= s1_q;
        if (s2_q == deb_q) cnt_q <= '0;
        else if (tick_ms) begin
          deb_q <= done ? s2_q : deb_q;
          cnt_q <= done ? '0 : cnt_q + DW'(1);
        end
      end
    end
  end

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    win_q, win_d;
  logic          clr_q, clr_d, ccnt_q, ccnt_d;
  logic [3:0]    prev_p1_q, prev_p2_q;
  logic          chg, ge1, ge2, start_p, pause_p;

  assign start_p = press[0];
  assign pause_p = press[1];
  assign chg = ~clr_q & ((p1_score != prev_p1_q) | (p2_score != prev_p2_q));
  assign ge1 = p1_score >= WIN;
  assign ge2 = p2_score >= WIN;

  // next state: match flow, point pause timer, winner capture and round-clear countdown
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    win_d   = win_q;
    clr_d   = clr_q;
    ccnt_d  = ccnt_q;
    if (clr_q && tick_ms) begin
      ccnt_d = ~ccnt_q;
      clr_d  = ~ccnt_q;
    end
    case (state_q)
      IDLE: state_d = (start_p && !clr_q) ? PLAY : IDLE;
      PLAY: begin
        if (chg && (ge1 || ge2)) begin
          state_d = OVER;
          win_d   = {ge2, ge1};
        end else if (chg) begin
          state_d = POINT;
          timer_d = '0;
        end else if (pause_p) state_d = IDLE;
      end
      POINT: if (tick_ms) begin
        timer_d = timer_q + TW'(1);
        state_d = (timer_q == TW'(POINT_MS - 1)) ? PLAY : POINT;
      end
      OVER: if (start_p) begin
        state_d = IDLE;
        win_d   = 2'b00;
        clr_d   = 1'b1;
        ccnt_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; previous scores track every clk except during round clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      win_q     <= 2'b00;
      clr_q     <= 1'b0;
      ccnt_q    <= 1'b0;
      prev_p1_q <= '0;
      prev_p2_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      win_q     <= win_d;
      clr_q     <= clr_d;
      ccnt_q    <= ccnt_d;
      prev_p1_q <= clr_q ? 4'd0 : p1_score;
      prev_p2_q <= clr_q ? 4'd0 : p2_score;
    end
  end

  assign game_state  = state_q;
  assign winner      = win_q;
  assign round_rst_n = ~clr_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed checks of game_ctrl match flow, debounce and reset
module tb_game_ctrl;
  logic       clk, reset, tick_ms, btn_start, btn_pause;
  logic [3:0] p1_score, p2_score;
  logic [1:0] game_state, winner;
  logic       round_rst_n;
  int         checks = 0;
  int         failures = 0;

  game_ctrl #(.WIN_SCORE(3), .POINT_MS(4), .DEBOUNCE_MS(2)) dut (
    .clk(clk), .reset(reset), .tick_ms(tick_ms), .btn_start(btn_start),
    .btn_pause(btn_pause), .p1_score(p1_score), .p2_score(p2_score),
    .game_state(game_state), .winner(winner), .round_rst_n(round_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) tick_ms = 1'b1;
    @(negedge clk) tick_ms = 1'b0;
  endtask

  task automatic set_btn(input bit pause, input logic v);
    if (pause) btn_pause = v;
    else btn_start = v;
  endtask

  task automatic hold(input bit pause);
    set_btn(pause, 1'b1);
    clks(3);
    tick();
    tick();
  endtask

  task automatic rel(input bit pause);
    set_btn(pause, 1'b0);
    clks(3);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b0; tick_ms = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    p1_score = 4'd0; p2_score = 4'd0;
    clks(3);
    check("rst_state", {2'b0, game_state}, 4'h0);
    check("rst_winner", {2'b0, winner}, 4'h0);
    check("rst_rrn", {3'b0, round_rst_n}, 4'h1);
    @(negedge clk) reset = 1'b1;
    clks(2);
    // short start pulse: one tick then bounce back
    btn_start = 1'b1;
    clks(3);
    tick();
    btn_start = 1'b0;
    clks(3);
    tick();
    tick();
    check("bounce_idle", {2'b0, game_state}, 4'h0);
    // start held: needs two fresh stable ticks
    btn_start = 1'b1;
    clks(3);
    tick();
    check("start_tick1", {2'b0, game_state}, 4'h0);
    tick();
    check("start_tick2", {2'b0, game_state}, 4'h1);
    tick();
    check("start_tick3", {2'b0, game_state}, 4'h1);
    rel(1'b0);
    check("release_play", {2'b0, game_state}, 4'h1);
    // point pause
    @(negedge clk) p1_score = 4'd1;
    @(negedge clk);
    check("point_enter", {2'b0, game_state}, 4'h2);
    tick(); tick(); tick();
    check("point_tick3", {2'b0, game_state}, 4'h2);
    tick();
    check("point_tick4", {2'b0, game_state}, 4'h1);
    // pause from play, then start again
    hold(1'b1);
    check("pause_idle", {2'b0, game_state}, 4'h0);
    rel(1'b1);
    hold(1'b1);
    check("pause_in_idle", {2'b0, game_state}, 4'h0);
    rel(1'b1);
    hold(1'b0);
    check("restart_play", {2'b0, game_state}, 4'h1);
    rel(1'b0);
    @(negedge clk) p2_score = 4'd2;
    @(negedge clk);
    check("point2_enter", {2'b0, game_state}, 4'h2);
    tick(); tick(); tick(); tick();
    check("point2_exit", {2'b0, game_state}, 4'h1);
    // winning score and pause press land on the same clk
    btn_pause = 1'b1;
    clks(3);
    tick();
    @(negedge clk) begin tick_ms = 1'b1; p2_score = 4'd3; end
    @(negedge clk) tick_ms = 1'b0;
    check("over_state", {2'b0, game_state}, 4'h3);
    check("over_winner_p2", {2'b0, winner}, 4'h2);
    rel(1'b1);
    check("over_pause_ign", {2'b0, game_state}, 4'h3);
    // start in over: round clear
    hold(1'b0);
    check("clr_state", {2'b0, game_state}, 4'h0);
    check("clr_rrn0", {3'b0, round_rst_n}, 4'h0);
    check("clr_winner", {2'b0, winner}, 4'h0);
    p1_score = 4'd0; p2_score = 4'd0;
    clks(2);
    tick();
    check("clr_tick1_rrn", {3'b0, round_rst_n}, 4'h0);
    tick();
    check("clr_tick2_rrn", {3'b0, round_rst_n}, 4'h1);
    check("clr_no_point", {2'b0, game_state}, 4'h0);
    rel(1'b0);
    check("clr_after_rel", {2'b0, game_state}, 4'h0);
    // tie
    hold(1'b0);
    check("tie_play", {2'b0, game_state}, 4'h1);
    rel(1'b0);
    @(negedge clk) begin p1_score = 4'd3; p2_score = 4'd3; end
    @(negedge clk);
    check("tie_over", {2'b0, game_state}, 4'h3);
    check("tie_winner", {2'b0, winner}, 4'h3);
    tick(); tick();
    check("tie_winner_hold", {2'b0, winner}, 4'h3);
    // reset in over clears the winner asynchronously
    @(negedge clk) #2 reset = 1'b0;
    #1 check("rst_over_winner", {2'b0, winner}, 4'h0);
    check("rst_over_state", {2'b0, game_state}, 4'h0);
    p1_score = 4'd0; p2_score = 4'd0;
    clks(2);
    @(negedge clk) reset = 1'b1;
    clks(2);
    hold(1'b0);
    check("rst2_play", {2'b0, game_state}, 4'h1);
    rel(1'b0);
    @(negedge clk) p1_score = 4'd1;
    @(negedge clk);
    check("rst2_point", {2'b0, game_state}, 4'h2);
    tick(); tick();
    @(negedge clk) #2 reset = 1'b0;
    #1 check("rst_point_state", {2'b0, game_state}, 4'h0);
    check("rst_point_winner", {2'b0, winner}, 4'h0);
    check("rst_point_rrn", {3'b0, round_rst_n}, 4'h1);
    p1_score = 4'd0;
    clks(2);
    @(negedge clk) reset = 1'b1;
    tick(); tick(); tick(); tick();
    check("post_rst_state", {2'b0, game_state}, 4'h0);
    check("post_rst_rrn", {3'b0, round_rst_n}, 4'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
